// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 size codes, FSM states and size helpers for the load/store unit
package load_store_unit_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_cls_t;

    // Unused funct3 encodings fall through to word.
    function automatic size_cls_t size_class(input logic [2:0] f3);
        case (f3)
            MEM_B, MEM_BU: size_class = SZ_BYTE;
            MEM_H, MEM_HU: size_class = SZ_HALF;
            default:       size_class = SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input size_cls_t cls, input logic [1:0] lo);
        case (cls)
            SZ_BYTE: align_lo = lo;
            SZ_HALF: align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication, byte-enable generation and load right-justification
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  size_cls_t   size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [31:0] lane_data,
    output logic [3:0]  lane_be,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    always_comb begin
        lane_data = st_data;
        lane_be   = 4'b1111;
        case (size)
            SZ_BYTE: begin
                lane_data = {4{st_data[7:0]}};
                lane_be   = 4'b0001 << st_lo;
            end
            SZ_HALF: begin
                lane_data = {2{st_data[15:0]}};
                lane_be   = 4'b0011 << st_lo;
            end
            default: begin
                lane_data = st_data;
                lane_be   = 4'b1111;
            end
        endcase
    end

    assign ld_data = ld_word >> {ld_lo, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory req/ack access stage; optional LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter bit LOAD_BE_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_size,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic [1:0]            lo_q, lo_d;
    logic                  mem_req_d, mem_we_d, resp_valid_d, resp_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]           mem_wdata_d, resp_rdata_d;
    logic [3:0]            mem_be_d;

    size_cls_t   cls;
    logic [1:0]  eff_lo;
    logic [31:0] lane_data, ld_data;
    logic [3:0]  lane_be;

    assign cls    = size_class(req_size);
    assign eff_lo = align_lo(cls, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (cls == SZ_HALF && req_addr[0]) ||
                        (cls == SZ_WORD && req_addr[1:0] != 2'b00);
`endif

    lsu_lane_align u_lane_align (
        .size      (cls),
        .st_lo     (eff_lo),
        .st_data   (req_wdata),
        .lane_data (lane_data),
        .lane_be   (lane_be),
        .ld_lo     (lo_q),
        .ld_word   (mem_rdata),
        .ld_data   (ld_data)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_be_d     = mem_be;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else
`endif
                    begin
                        state_d     = ST_BUS;
                        lo_d        = eff_lo;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = lane_data;
                        mem_be_d    = (req_we || !LOAD_BE_FULL) ? lane_be : 4'b1111;
                        resp_err_d  = 1'b0;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we ? 32'h0 : ld_data;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Async reset abandons any in-flight bus cycle without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lo_q       <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_be     <= mem_be_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-lane memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] d,
                          input logic [2:0] f3, input int delay);
        int n, a_lo, idx;
        bit mis;
        logic [31:0] ea, ew, rd, mask;
        logic [3:0] eb;
        n    = nbytes(f3);
        a_lo = int'(addr[1:0]);
        mis  = (a_lo % n) != 0;
        a_lo = a_lo - (a_lo % n);
        ea   = {addr[31:2], 2'b00};
        eb   = we ? 4'(((1 << n) - 1) << a_lo) : 4'hF;
        ew   = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
        mask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        idx  = int'(addr[7:2]);

        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d; req_size = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            check("trap_no_mem_req", {31'h0, mem_req}, 32'h0);
            check("trap_resp_valid", {31'h0, resp_valid}, 32'h1);
            check("trap_resp_err", {31'h0, resp_err}, 32'h1);
            check("trap_resp_rdata", resp_rdata, 32'h0);
            @(posedge clk); #1;
            check("trap_resp_pulse", {31'h0, resp_valid}, 32'h0);
            check("trap_ready", {31'h0, req_ready}, 32'h1);
            return;
        end
`else
        if (mis) n_tests = n_tests + 0;
`endif
        check("mem_req_issue", {31'h0, mem_req}, 32'h1);
        check("mem_we", {31'h0, mem_we}, {31'h0, we});
        check("mem_addr", mem_addr, ea);
        check("mem_be", {28'h0, mem_be}, {28'h0, eb});
        if (we) check("mem_wdata", mem_wdata, ew);
        check("busy_bus", {31'h0, busy}, 32'h1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check("mem_req_hold", {31'h0, mem_req}, 32'h1);
            check("mem_addr_hold", mem_addr, ea);
            check("no_early_resp", {31'h0, resp_valid}, 32'h0);
        end
        mem_ack   = 1'b1;
        mem_rdata = mem[idx];
        rd        = we ? 32'h0 : (mem[idx] >> (8 * a_lo));
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("resp_valid", {31'h0, resp_valid}, 32'h1);
        check("mem_req_drop", {31'h0, mem_req}, 32'h0);
        check("busy_resp", {31'h0, busy}, 32'h1);
        check("resp_err", {31'h0, resp_err}, 32'h0);
        check("resp_rdata", resp_rdata & mask, rd & mask);
        if (we)
            for (int i = 0; i < 4; i++)
                if (eb[i]) mem[idx][8*i +: 8] = ew[8*i +: 8];
        @(posedge clk); #1;
        check("resp_pulse_end", {31'h0, resp_valid}, 32'h0);
        check("busy_clear", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [2:0] codes [8];
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk); rst = 1'b0;

        access(1'b1, 32'h103, 32'h0000_00AB, 3'b000, 0);
        mem[0] = 32'hBEEF_1234;
        access(1'b0, 32'h102, 32'h0, 3'b001, 0);
        access(1'b0, 32'h200, 32'h0, 3'b010, 5);
        access(1'b0, 32'h202, 32'h0, 3'b010, 1);
        access(1'b1, 32'h300, 32'hCAFE_F00D, 3'b010, 0);
        access(1'b0, 32'h300, 32'h0, 3'b010, 0);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200; req_size = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end

        for (int t = 0; t < 150; t++)
            access(1'($urandom % 2), 32'($urandom_range(0, 255)), $urandom,
                   codes[$urandom_range(0, 7)], $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
